// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, addresses the synchronous instruction memory and
// buffers one-cycle-latency returns in a prefetch FIFO presented to decode via valid/ready.
module instruction_fetch_unit #(
  parameter int PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fetch_enable,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] mem_readAddress,
  input  logic [31:0]         mem_instruction,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst_out,
  output logic [PC_WIDTH-1:0] inst_pc
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic run, pop, push, issue, inflight;
  logic [PC_WIDTH-1:0] pc, inflight_pc;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [CW:0] used;
  logic [31:0] fifo_inst [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] fifo_pc [FIFO_DEPTH];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;

  always_comb state_nx = fetch_enable ? RUN : IDLE;

  // The enabling cycle itself already issues, so fetch starts without a bubble.
  always_comb run = state == RUN || state_nx == RUN;

  assign inst_valid = count != '0;
  assign pop = inst_valid && inst_ready;
  assign push = inflight && !redirect_valid;
  assign used = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = run && fetch_enable && !redirect_valid && used < (CW+1)'(FIFO_DEPTH);
  assign mem_readAddress = pc >> 2;
  assign inst_out = inst_valid ? fifo_inst[head] : '0;
  assign inst_pc = inst_valid ? fifo_pc[head] : '0;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~PC_WIDTH'(3);
      inflight <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (issue) begin
        pc <= pc + PC_WIDTH'(4);
        inflight_pc <= pc;
      end
      inflight <= issue;
      if (push) tail <= nxt(tail);
      if (pop) head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
    end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clock)
    if (push) begin
      fifo_inst[tail] <= mem_instruction;
      fifo_pc[tail] <= inflight_pc;
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vector table plus randomized run against a queue-based
// model of the fetch stream; the bench also plays the synchronous instruction memory.
module tb_instruction_fetch_unit;
  localparam int W = 64;
  localparam int D = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic fetch_enable = 1'b0;
  logic redirect_valid = 1'b0;
  logic inst_ready = 1'b0;
  logic [W-1:0] redirect_pc = '0;
  logic [W-1:0] mem_readAddress, inst_pc;
  logic [31:0] mem_instruction, inst_out;
  logic inst_valid;
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  instruction_fetch_unit #(.PC_WIDTH(W), .RESET_PC('0), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .fetch_enable(fetch_enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_readAddress(mem_readAddress), .mem_instruction(mem_instruction),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc)
  );

  function automatic logic [31:0] mem_word(input logic [W-1:0] idx);
    return idx == 0 ? 32'h8B1F03E5 : idx == 1 ? 32'hF84000A4 :
           idx == 2 ? 32'h8B040086 : idx == 3 ? 32'hF80010A6 :
           (idx[31:0] * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  always @(posedge clock) mem_instruction <= mem_word(mem_readAddress);

  typedef struct {
    logic rst, fe, rv, rdy;
    logic [W-1:0] rpc;
    logic ev;
    logic [W-1:0] epc, emra;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t v(input logic rst, input logic fe, input logic rv, input logic rdy,
                             input logic [W-1:0] rpc, input logic ev,
                             input logic [W-1:0] epc, input logic [W-1:0] emra);
    vec_t r;
    r.rst = rst; r.fe = fe; r.rv = rv; r.rdy = rdy; r.rpc = rpc;
    r.ev = ev; r.epc = epc; r.emra = emra;
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [W-1:0] epc,
                           input logic [W-1:0] emra);
    chk({tag, " valid"}, W'(inst_valid), W'(ev));
    chk({tag, " pc"}, inst_pc, ev ? epc : '0);
    chk({tag, " inst"}, W'(inst_out), ev ? W'(mem_word(epc >> 2)) : '0);
    chk({tag, " addr"}, mem_readAddress, emra);
  endtask

  task automatic drive(input logic rst, input logic fe, input logic rv, input logic rdy,
                       input logic [W-1:0] rpc);
    @(negedge clock);
    reset = rst; fetch_enable = fe; redirect_valid = rv; inst_ready = rdy; redirect_pc = rpc;
    #1;
  endtask

  // Reference: delivered PCs held as a queue, plus one outstanding memory read.
  logic [W-1:0] mq[$];
  logic m_infl;
  logic [W-1:0] m_ipc, m_pc;

  task automatic model_reset();
    mq.delete();
    m_infl = 1'b0;
    m_ipc = '0;
    m_pc = '0;
  endtask

  task automatic model_step(input logic fe, input logic rv, input logic rdy, input logic [W-1:0] rpc);
    int n;
    logic pop, iss;
    n = mq.size();
    pop = n > 0 && rdy;
    iss = fe && !rv && (n + int'(m_infl) - int'(pop) < D);
    if (rv) begin
      mq.delete();
      m_infl = 1'b0;
      m_pc = rpc & ~64'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_infl) mq.push_back(m_ipc);
      m_infl = iss;
      if (iss) begin
        m_ipc = m_pc;
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  initial begin
    // plain stream from reset
    tv.push_back(v(1,1,0,1,0, 0,0,0));
    tv.push_back(v(0,1,0,1,0, 0,0,0));
    tv.push_back(v(0,1,0,1,0, 0,0,1));
    tv.push_back(v(0,1,0,1,0, 1,0,2));
    tv.push_back(v(0,1,0,1,0, 1,4,3));
    tv.push_back(v(0,1,0,1,0, 1,8,4));
    tv.push_back(v(0,1,0,1,0, 1,12,5));
    // backpressure fills the FIFO, then release; then reset with FIFO occupied
    tv.push_back(v(1,1,0,0,0, 0,0,0));
    tv.push_back(v(0,1,0,0,0, 0,0,0));
    tv.push_back(v(0,1,0,0,0, 0,0,1));
    tv.push_back(v(0,1,0,0,0, 1,0,2));
    tv.push_back(v(0,1,0,0,0, 1,0,2));
    tv.push_back(v(0,1,0,0,0, 1,0,2));
    tv.push_back(v(0,1,0,1,0, 1,0,2));
    tv.push_back(v(0,1,0,1,0, 1,4,3));
    tv.push_back(v(0,1,0,0,0, 1,8,4));
    tv.push_back(v(0,1,0,0,0, 1,8,4));
    tv.push_back(v(1,1,0,1,0, 0,0,0));
    tv.push_back(v(0,1,0,1,0, 0,0,0));
    tv.push_back(v(0,1,0,1,0, 0,0,1));
    tv.push_back(v(0,1,0,1,0, 1,0,2));
    tv.push_back(v(0,1,0,1,0, 1,4,3));
    // redirect with an occupied FIFO and a read outstanding
    tv.push_back(v(1,1,0,0,0, 0,0,0));
    tv.push_back(v(0,1,0,0,0, 0,0,0));
    tv.push_back(v(0,1,0,0,0, 0,0,1));
    tv.push_back(v(0,1,1,0,'h40, 1,0,2));
    tv.push_back(v(0,1,0,1,0, 0,0,'h10));
    tv.push_back(v(0,1,0,1,0, 0,0,'h11));
    tv.push_back(v(0,1,0,1,0, 1,'h40,'h12));
    tv.push_back(v(0,1,0,1,0, 1,'h44,'h13));
    // unaligned redirect while streaming; the head pop still completes
    tv.push_back(v(1,1,0,1,0, 0,0,0));
    tv.push_back(v(0,1,0,1,0, 0,0,0));
    tv.push_back(v(0,1,0,1,0, 0,0,1));
    tv.push_back(v(0,1,0,1,0, 1,0,2));
    tv.push_back(v(0,1,1,1,'h43, 1,4,3));
    tv.push_back(v(0,1,0,1,0, 0,0,'h10));
    tv.push_back(v(0,1,0,1,0, 0,0,'h11));
    tv.push_back(v(0,1,0,1,0, 1,'h40,'h12));
    tv.push_back(v(0,1,0,1,0, 1,'h44,'h13));
    // enable drops with a read outstanding, then resumes
    tv.push_back(v(1,1,0,1,0, 0,0,0));
    tv.push_back(v(0,1,0,1,0, 0,0,0));
    tv.push_back(v(0,0,0,1,0, 0,0,1));
    tv.push_back(v(0,0,0,1,0, 1,0,1));
    tv.push_back(v(0,0,0,1,0, 0,0,1));
    tv.push_back(v(0,1,0,1,0, 0,0,1));
    tv.push_back(v(0,1,0,1,0, 0,0,2));
    tv.push_back(v(0,1,0,1,0, 1,4,3));
    // PC wraps past the top of the address space
    tv.push_back(v(1,0,0,1,0, 0,0,0));
    tv.push_back(v(0,0,1,1,64'hFFFF_FFFF_FFFF_FFFE, 0,0,0));
    tv.push_back(v(0,1,0,1,0, 0,0,64'h3FFF_FFFF_FFFF_FFFF));
    tv.push_back(v(0,1,0,1,0, 0,0,0));
    tv.push_back(v(0,1,0,1,0, 1,64'hFFFF_FFFF_FFFF_FFFC,1));
    tv.push_back(v(0,1,0,1,0, 1,0,2));

    repeat (2) @(negedge clock);
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].fe, tv[i].rv, tv[i].rdy, tv[i].rpc);
      check_out($sformatf("vec%0d", i), tv[i].ev, tv[i].epc, tv[i].emra);
    end

    // reset asserted mid-cycle must clear outputs without waiting for an edge
    @(posedge clock);
    #2;
    chk("pre_async valid", W'(inst_valid), W'(1));
    reset = 1'b1;
    #1;
    chk("async valid", W'(inst_valid), '0);
    chk("async addr", mem_readAddress, '0);

    for (int i = 0; i < 3000; i++) begin
      logic rst, fe, rv, rdy;
      logic [W-1:0] rpc;
      rst = i == 0 || $urandom_range(0, 299) == 0;
      fe = $urandom_range(0, 9) != 0;
      rv = $urandom_range(0, 19) == 0;
      rdy = $urandom_range(0, 3) != 0;
      rpc = $urandom_range(0, 7) == 0 ? {32'hFFFF_FFFF, 32'hFFFF_FFFF - 32'($urandom_range(0, 63))}
                                      : W'($urandom_range(0, 'hFFFF));
      drive(rst, fe, rv, rdy, rpc);
      if (rst) model_reset();
      check_out($sformatf("rnd%0d", i), mq.size() > 0, mq.size() > 0 ? mq[0] : '0, m_pc >> 2);
      if (!rst) model_step(fe, rv, rdy, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
